// File: rtl/pack_burst_sched_pkg.sv
// Shared definitions for the pixel-pack / burst scheduler: FSM state encoding
// and the packed-word geometry.
package pack_burst_sched_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_LINE  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;

    localparam int unsigned OSIZE_DEFAULT  = 256;
    localparam int unsigned BYTES_PER_WORD = OSIZE_DEFAULT / 8;

endpackage

// File: rtl/pack_burst_sched_burst_issue.sv
// Burst generator: tracks packed words waiting in the downstream FIFO and
// turns them into AXI write burst requests that never cross a line.
module burst_issue
    import pack_burst_sched_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int PEND_W    = 7,
    parameter int ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    input  logic              drain,
    input  logic              bur_ack,
    output logic              bur_req,
    output logic [ADDR_W-1:0] bur_addr,
    output logic [8:0]        bur_len,
    output logic [PEND_W-1:0] pend
);

    localparam logic [31:0] FULL_WORDS = 32'(BURST_LEN);

    logic              fire;
    logic [PEND_W-1:0] pend_sub;
    logic [31:0]       pend_ext;

    assign fire     = bur_req & bur_ack;
    assign pend_sub = fire ? PEND_W'(bur_len) : '0;
    assign pend_ext = 32'(pend);

    // A request only ever asks for words already counted in pend, so the
    // subtraction on ack cannot underflow even with a same-cycle increment.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            bur_req  <= 1'b0;
            bur_addr <= '0;
            bur_len  <= '0;
        end else begin
            // NOTE: every register here updates with <=, so each branch reads the
            // pre-edge pend/bur_len regardless of statement order.
            pend <= pend + PEND_W'(inc) - pend_sub;

            if (load)
                bur_addr <= load_addr;
            else if (fire)
                bur_addr <= bur_addr + ADDR_W'(bur_len) * ADDR_W'(BYTES_PER_WORD);

            if (fire) begin
                bur_req <= 1'b0;
            end else if (!bur_req) begin
                if (pend_ext >= FULL_WORDS) begin
                    bur_req <= 1'b1;
                    bur_len <= 9'(BURST_LEN);
                end else if (drain && pend != '0) begin
                    bur_req <= 1'b1;
                    bur_len <= 9'(pend);
                end
            end
        end
    end

endmodule

// File: rtl/pack_burst_sched.sv
// Frame/line sequencer feeding a pixel combiner and scheduling the AXI write
// bursts that move its packed words to memory, one line at a time.
module pack_burst_sched
    import pack_burst_sched_pkg::*;
#(
    parameter int ISIZE      = 24,
    parameter int OSIZE      = OSIZE_DEFAULT,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_WORDS = 64,
    parameter int ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [15:0]       cfg_hsize,
    input  logic [15:0]       cfg_vsize,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              comb_wr_en,
    output logic              comb_align,
    output logic              comb_last,
    input  logic              comb_owr_en,
    input  logic              comb_olast_en,
    output logic              bur_req,
    input  logic              bur_ack,
    output logic [ADDR_W-1:0] bur_addr,
    output logic [8:0]        bur_len
);

    localparam int PEND_W = $clog2(FIFO_WORDS + 1);
    // Words that can still land after in_ready drops: two cycles of combiner
    // latency plus the pixel accepted in the current cycle.
    localparam int HEADROOM = 2 * ((ISIZE + OSIZE - 1) / OSIZE) + 1;
    localparam logic [PEND_W-1:0] READY_MAX = PEND_W'(FIFO_WORDS - HEADROOM);

    logic [2:0]        state;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] line_base;
    logic [15:0]       hsize_q;
    logic [15:0]       vsize_q;
    logic [15:0]       pix_cnt;
    logic [15:0]       line_cnt;
    logic [PEND_W-1:0] pend;
    logic              word_inc;
    logic              last_pix;
    logic              last_line;
    logic              drain;

    assign word_inc   = comb_owr_en | comb_olast_en;
    assign drain      = (state == ST_DRAIN);
    assign in_ready   = (state == ST_LINE) && (pend <= READY_MAX);
    assign comb_wr_en = in_valid & in_ready;
    assign last_pix   = (pix_cnt == hsize_q - 16'd1);
    assign comb_last  = comb_wr_en & last_pix;
    assign comb_align = (state == ST_ALIGN);
    assign busy       = (state != ST_IDLE);
    assign last_line  = (line_cnt == vsize_q - 16'd1);
    assign done       = (state == ST_NEXT) && last_line;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stride_q  <= '0;
            line_base <= '0;
            hsize_q   <= '0;
            vsize_q   <= '0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stride_q  <= cfg_stride;
                        hsize_q   <= cfg_hsize;
                        vsize_q   <= cfg_vsize;
                        line_base <= cfg_base;
                        pix_cnt   <= '0;
                        line_cnt  <= '0;
                        state     <= ST_ALIGN;
                    end
                end
                ST_ALIGN: state <= ST_LINE;
                ST_LINE: begin
                    if (comb_wr_en) begin
                        if (last_pix) begin
                            pix_cnt <= '0;
                            state   <= ST_FLUSH;
                        end else begin
                            pix_cnt <= pix_cnt + 16'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (comb_olast_en)
                        state <= ST_DRAIN;
                end
                // Leave only once the final partial burst has been acknowledged.
                ST_DRAIN: begin
                    if (pend == '0 && !bur_req)
                        state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (last_line) begin
                        state <= ST_IDLE;
                    end else begin
                        line_cnt  <= line_cnt + 16'd1;
                        line_base <= line_base + stride_q;
                        state     <= ST_ALIGN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    burst_issue #(
        .BURST_LEN (BURST_LEN),
        .PEND_W    (PEND_W),
        .ADDR_W    (ADDR_W)
    ) u_issue (
        .clock     (clock),
        .rst_n     (rst_n),
        .load      (comb_align),
        .load_addr (line_base),
        .inc       (word_inc),
        .drain     (drain),
        .bur_ack   (bur_ack),
        .bur_req   (bur_req),
        .bur_addr  (bur_addr),
        .bur_len   (bur_len),
        .pend      (pend)
    );

endmodule

// File: doc/pack_burst_sched.md
PACK_BURST_SCHED -- requirements
Module: pack_burst_sched

Interface
REQ-001 ISIZE, 24, pixel width in bits presented to the pixel combiner.
REQ-002 OSIZE, 256, packed memory word width in bits.
REQ-003 BURST_LEN, 16, maximum AXI write burst length in words, range 1..256.
REQ-004 FIFO_WORDS, 64, depth in words of the downstream packed-word FIFO.
REQ-005 ADDR_W, 32, byte address width.
REQ-006 clock  in  1  clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset; asynchronous, active-low.
REQ-008 start  in  1  one-cycle pulse that begins a frame; ignored unless idle.
REQ-009 cfg_base  in  ADDR_W  frame base byte address, sampled on start.
REQ-010 cfg_stride  in  ADDR_W  line stride in bytes, sampled on start.
REQ-011 cfg_hsize  in  16  pixels per line (>=1), sampled on start.
REQ-012 cfg_vsize  in  16  lines per frame (>=1), sampled on start.
REQ-013 busy  out  1  high from the cycle after start until done.
REQ-014 done  out  1  one-cycle pulse when the last burst of the frame is acknowledged.
REQ-015 in_valid / in_ready  in / out  1 / 1  pixel handshake; transfer when both are high.
REQ-016 comb_wr_en  out  1  equals in_valid & in_ready.
REQ-017 comb_align  out  1  one-cycle realign pulse to the combiner before each line.
REQ-018 comb_last  out  1  high together with comb_wr_en on the last pixel of a line.
REQ-019 comb_owr_en / comb_olast_en  in / in  1 / 1  combiner full-word and last-word strobes.
REQ-020 bur_req / bur_ack  out / in  1 / 1  burst request, held until the ack cycle.
REQ-021 bur_addr  out  ADDR_W  burst start byte address, stable while bur_req is high.
REQ-022 bur_len  out  9  burst length in words (1..BURST_LEN), stable while bur_req is high.

Function
REQ-023 The FSM SHALL have the states IDLE, ALIGN, LINE, FLUSH, DRAIN and NEXT; IDLE->ALIGN on start; ALIGN (one cycle, comb_align=1)->LINE.
REQ-024 In LINE, the block SHALL count accepted pixels; the pixel whose count equals cfg_hsize-1 SHALL assert comb_last, and the FSM SHALL then go to FLUSH.
REQ-025 In FLUSH, the block SHALL wait for comb_olast_en, then go to DRAIN.
REQ-026 The word counter pend SHALL be incremented by 1 in any cycle where comb_owr_en|comb_olast_en is high; both strobes in the same cycle count as one word.
REQ-027 bur_req SHALL rise when pend>=BURST_LEN (bur_len=BURST_LEN), or in DRAIN when 0<pend<BURST_LEN (bur_len=pend).
REQ-028 On bur_ack, the block SHALL set pend to pend+inc-bur_len (simultaneous increment honoured), advance the address by bur_len*OSIZE/8, and drop bur_req for at least one cycle.
REQ-029 In DRAIN, when pend=0 and no request is outstanding, the FSM SHALL go to NEXT; NEXT SHALL set the line address to line_base+cfg_stride and go to ALIGN, or, if this was line cfg_vsize-1, pulse done and go to IDLE.
REQ-030 in_ready SHALL be high only in LINE and only while pend <= FIFO_WORDS-3, which covers the combiner's 2-cycle latency.
REQ-031 Bursts SHALL never span lines; the first burst of line n SHALL start at cfg_base+n*cfg_stride.
REQ-032 A start pulse while busy SHALL be ignored; configuration changes while busy SHALL have no effect.
REQ-033 pend SHALL be wide enough to hold FIFO_WORDS and SHALL never underflow.

Reset
REQ-034 While rst_n is low: FSM=IDLE, and busy, done, in_ready, comb_wr_en, comb_align, comb_last and bur_req are 0; bur_addr, bur_len, pend and all counters are 0.
REQ-035 Reset mid-frame SHALL abandon the frame immediately, with no done pulse; the next start SHALL run a full frame.

Structure
REQ-036 The shared vdma package SHALL hold the FSM state encoding and the bytes-per-word constant OSIZE/8.
REQ-037 The burst request/length/address generator SHALL be a sub-module named burst_issue; the pixel and line FSM SHALL stay in the top level.

Verification
REQ-038 ISIZE=24, OSIZE=256, hsize=32, vsize=1, in_valid always high -> 3 words, one burst with len=3 at cfg_base, then done.
REQ-039 hsize=1920, vsize=2, stride=0x2000, base=0x1000 -> per line, 11 bursts of 16 and 1 of 4; line 1 starts at 0x3000; exactly one done pulse.
REQ-040 bur_ack withheld for 100 cycles -> in_ready falls once pend=62; no word lost; pend never exceeds 64.
REQ-041 bur_ack arriving in the same cycle as comb_owr_en with pend=16 -> pend=1 afterwards.
REQ-042 rst_n low mid-line, then start -> all outputs 0 during reset; the new frame's first burst is at the new cfg_base.
REQ-043 start pulsed while busy with different cfg values -> ignored; addresses still follow the original configuration.
